// File: rtl/dsadc_pkg.sv
// Shared types and helpers for the dual-slope ADC controller.
// DSADC_CMP_SYNC_EN selects the two-flop comparator synchroniser build.
package dsadc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AZ,
        INT,
        DEINT
    } dsadc_state_e;

`ifdef DSADC_CMP_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    function automatic int phase_w(input int len);
        return (len <= 1) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/dsadc_cntr.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
module dsadc_cntr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_syncClr,
    input  logic         i_en,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_cnt <= '0;
        else if (i_syncClr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != i_max))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_max);

endmodule

// File: rtl/dl_slp_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed integration, timed de-integration.
// Define DSADC_CMP_SYNC_EN to pass cmp_out through a 2-flop synchroniser.
module dl_slp_ctrl
    import dsadc_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int T_INT  = 256,
    parameter int AZ_CYC = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_out,
    output logic             integrator_rstn,
    output logic             integrator_sel,
    output logic             busy,
    output logic             eoc,
    output logic [CNT_W-1:0] dig_out,
    output logic             ovf
);

    localparam int AZ_W = phase_w(AZ_CYC);
    localparam int TI_W = phase_w(T_INT);
    localparam int PH_W = (AZ_W > TI_W) ? AZ_W : TI_W;
    localparam logic [PH_W-1:0] AZ_LAST  = PH_W'(AZ_CYC - 1);
    localparam logic [PH_W-1:0] INT_LAST = PH_W'(T_INT - 1);

    dsadc_state_e     r_state;
    dsadc_state_e     w_next;
    logic [PH_W-1:0]  w_phaseCnt;
    logic [PH_W-1:0]  w_phaseMax;
    logic             w_phaseTc;
    logic [CNT_W-1:0] w_measCnt;
    logic             w_measTc;
    logic             w_cmpS;
    logic [CNT_W-1:0] w_code;
    logic             w_done;
    logic             w_unused;

    // One phase counter serves both AZ and INT; it restarts on every state change.
    assign w_phaseMax = (r_state == AZ) ? AZ_LAST : INT_LAST;

    dsadc_cntr #(.W(PH_W)) u_phaseCntr (
        .clk       (clk),
        .rstn      (rstn),
        .i_syncClr (w_next != r_state),
        .i_en      ((r_state == AZ) || (r_state == INT)),
        .i_max     (w_phaseMax),
        .o_cnt     (w_phaseCnt),
        .o_tc      (w_phaseTc)
    );

    assign w_unused = ^w_phaseCnt;

    dsadc_cntr #(.W(CNT_W)) u_measCntr (
        .clk       (clk),
        .rstn      (rstn),
        .i_syncClr (r_state != DEINT),
        .i_en      ((r_state == DEINT) && !w_cmpS),
        .i_max     ({CNT_W{1'b1}}),
        .o_cnt     (w_measCnt),
        .o_tc      (w_measTc)
    );

`ifdef DSADC_CMP_SYNC_EN
    logic r_cmpMeta;
    logic r_cmpSync;

    // Only crossings seen during DEINT enter the synchroniser, so stale values never leak in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmpMeta <= 1'b0;
            r_cmpSync <= 1'b0;
        end else begin
            r_cmpMeta <= cmp_out && (r_state == DEINT);
            r_cmpSync <= r_cmpMeta;
        end
    end

    assign w_cmpS = r_cmpSync;
    assign w_code = (w_measCnt >= CNT_W'(SYNC_LAT)) ? (w_measCnt - CNT_W'(SYNC_LAT)) : '0;
`else
    assign w_cmpS = cmp_out;
    assign w_code = w_measCnt;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next = AZ;
                AZ:      if (w_phaseTc) w_next = INT;
                INT:     if (w_phaseTc) w_next = DEINT;
                DEINT:   if (w_cmpS || w_measTc) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        integrator_rstn = 1'b0;
        integrator_sel  = 1'b0;
        busy            = 1'b1;
        case (r_state)
            IDLE:    busy = 1'b0;
            INT: begin
                integrator_rstn = 1'b1;
                integrator_sel  = 1'b1;
            end
            DEINT:   integrator_rstn = 1'b1;
            default: ;
        endcase
    end

    // A crossing wins over overflow when both land in the same cycle.
    assign w_done = (r_state == DEINT) && !abort && (w_cmpS || w_measTc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eoc     <= 1'b0;
            dig_out <= '0;
            ovf     <= 1'b0;
        end else begin
            eoc <= w_done;
            if (w_done) begin
                dig_out <= w_cmpS ? w_code : {CNT_W{1'b1}};
                ovf     <= !w_cmpS;
            end
        end
    end

endmodule

// File: tb/tb_dl_slp_ctrl.sv
// Directed self-checking bench for dl_slp_ctrl (CNT_W=8, T_INT=16, AZ_CYC=4).
module tb_dl_slp_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       abort;
    logic       cmp_out;
    logic       integrator_rstn;
    logic       integrator_sel;
    logic       busy;
    logic       eoc;
    logic [7:0] dig_out;
    logic       ovf;

    int errors  = 0;
    int checks  = 0;
    int busyCnt = 0;
    int eocCnt  = 0;

    always #5 clk = ~clk;

    dl_slp_ctrl #(
        .CNT_W  (8),
        .T_INT  (16),
        .AZ_CYC (4)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .abort           (abort),
        .cmp_out         (cmp_out),
        .integrator_rstn (integrator_rstn),
        .integrator_sel  (integrator_sel),
        .busy            (busy),
        .eoc             (eoc),
        .dig_out         (dig_out),
        .ovf             (ovf)
    );

    // Busy and eoc are counted once per cycle on the falling edge.
    always @(negedge clk) begin
        if (busy) busyCnt++;
        if (eoc) eocCnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic c);
        start   = s;
        abort   = a;
        cmp_out = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_intrstn"}, 32'(integrator_rstn), 0);
        checkOutput({tag, "_sel"}, 32'(integrator_sel), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_eoc"}, 32'(eoc), 0);
        checkOutput({tag, "_dig"}, 32'(dig_out), 0);
        checkOutput({tag, "_ovf"}, 32'(ovf), 0);
    endtask

    // Returns on the falling edge inside DEINT cycle 0.
    task automatic startToDeint();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(20);
    endtask

    initial begin
        rstn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        checkReset("rst");
        rstn = 1'b1;
        tick(2);
        checkOutput("idle_busy", 32'(busy), 0);

        $display("[TB] nominal conversion, crossing at DEINT cycle 100");
        busyCnt = 0;
        eocCnt  = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        checkOutput("az_busy", 32'(busy), 1);
        checkOutput("az_intrstn", 32'(integrator_rstn), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("az_last_sel", 32'(integrator_sel), 0);
        tick(1);
        checkOutput("int_sel", 32'(integrator_sel), 1);
        checkOutput("int_intrstn", 32'(integrator_rstn), 1);
        tick(16);
        checkOutput("deint_sel", 32'(integrator_sel), 0);
        checkOutput("deint_intrstn", 32'(integrator_rstn), 1);
        checkOutput("deint_busy", 32'(busy), 1);
        tick(100);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("nom_eoc", 32'(eoc), 1);
        checkOutput("nom_dig", 32'(dig_out), 100);
        checkOutput("nom_ovf", 32'(ovf), 0);
        checkOutput("nom_busy_drop", 32'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("nom_eoc_pulse", 32'(eoc), 0);
        checkOutput("nom_dig_hold", 32'(dig_out), 100);
        tick(3);
        checkOutput("nom_busy_cycles", 32'(busyCnt), 121);
        checkOutput("nom_eoc_count", 32'(eocCnt), 1);

        $display("[TB] overflow, comparator never crosses");
        startToDeint();
        tick(255);
        checkOutput("ovf_pre_eoc", 32'(eoc), 0);
        checkOutput("ovf_pre_busy", 32'(busy), 1);
        tick(1);
        checkOutput("ovf_eoc", 32'(eoc), 1);
        checkOutput("ovf_dig", 32'(dig_out), 255);
        checkOutput("ovf_flag", 32'(ovf), 1);
        checkOutput("ovf_busy", 32'(busy), 0);
        tick(2);

        $display("[TB] crossing exactly at full scale");
        startToDeint();
        tick(255);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("sim_eoc", 32'(eoc), 1);
        checkOutput("sim_dig", 32'(dig_out), 255);
        checkOutput("sim_ovf", 32'(ovf), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);

        $display("[TB] abort in INT cycle 8 with an ignored start");
        eocCnt = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(8);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("abt_in_int", 32'(integrator_sel), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("abt_busy", 32'(busy), 0);
        checkOutput("abt_sel", 32'(integrator_sel), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(40);
        checkOutput("abt_noqueue", 32'(busy), 0);
        checkOutput("abt_no_eoc", 32'(eocCnt), 0);
        checkOutput("abt_dig_kept", 32'(dig_out), 255);
        checkOutput("abt_ovf_kept", 32'(ovf), 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("abt_over_start", 32'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);

        $display("[TB] async reset mid-DEINT then a crossing at cycle 50");
        startToDeint();
        tick(30);
        #2 rstn = 1'b0;
        #1 checkReset("arst");
        @(negedge clk);
        rstn = 1'b1;
        tick(2);
        checkOutput("arst_idle", 32'(busy), 0);
        eocCnt = 0;
        startToDeint();
        tick(50);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("post_eoc", 32'(eoc), 1);
        checkOutput("post_dig", 32'(dig_out), 50);
        checkOutput("post_ovf", 32'(ovf), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("post_eoc_count", 32'(eocCnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
